// File: rtl/stream_mux_arb_if.sv
// stream_mux_arb_if: valid/ready bundle between the producers, the stream mux and its consumer
interface stream_mux_arb_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS*WIDTH-1:0]   in_data;
    logic [CHANNELS-1:0]         in_valid;
    logic [CHANNELS-1:0]         in_ready;
    logic [WIDTH-1:0]            out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [$clog2(CHANNELS)-1:0] out_chan;
    logic [15:0]                 xfer_cnt;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_chan, xfer_cnt
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_chan, xfer_cnt
    );
endinterface

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel valid/ready stream mux with a registered output; define STREAM_MUX_RR_EN to add round-robin mode
module stream_mux_arb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(CHANNELS)-1:0] i_sel,
    input  logic                        i_mode,
    stream_mux_arb_if.slave             bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0]    r_data;
    logic [SEL_W-1:0]    r_chan;
    logic                r_valid;
    logic [15:0]         r_cnt;
    logic                w_load;
    logic                w_hit;
    logic                w_man_hit;
    logic [SEL_W-1:0]    w_g;
    logic [CHANNELS-1:0] w_in_ready;

    assign w_load    = rst_n && (!r_valid || bus.out_ready);
    assign w_man_hit = (32'(i_sel) < CHANNELS) && bus.in_valid[i_sel];

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] r_ptr;
    logic             w_rr_hit;
    logic [SEL_W-1:0] w_rr_g;
    logic [SEL_W-1:0] w_idx;

    // scan from ptr+CHANNELS down to ptr+1 so the valid channel nearest after ptr wins
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_g   = '0;
        w_idx    = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            w_idx = SEL_W'((int'(r_ptr) + k) % CHANNELS);
            if (bus.in_valid[w_idx]) begin
                w_rr_hit = 1'b1;
                w_rr_g   = w_idx;
            end
        end
    end

    assign w_hit = i_mode ? w_rr_hit : w_man_hit;
    assign w_g   = i_mode ? w_rr_g : i_sel;

    // pointer moves only on accepts made in round-robin mode; reset gives channel 0 first turn
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ptr <= SEL_W'(CHANNELS - 1);
        else if (w_hit && w_load && i_mode)
            r_ptr <= w_g;
    end
`else
    logic w_unused;

    assign w_unused = i_mode;
    assign w_hit    = w_man_hit;
    assign w_g      = i_sel;
`endif

    // ready goes only to the granted channel, and only when the output slot can take a word
    always_comb begin
        w_in_ready = '0;
        if (w_hit)
            w_in_ready[w_g] = w_load;
    end

    // output slot: load on accept, empty when loadable with no grant, hold on stall; count handshakes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_load) begin
                r_valid <= w_hit;
                if (w_hit) begin
                    r_data <= bus.in_data[w_g*WIDTH +: WIDTH];
                    r_chan <= w_g;
                end
            end
            if (r_valid && bus.out_ready)
                r_cnt <= r_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.out_chan  = r_chan;
    assign bus.xfer_cnt  = r_cnt;
endmodule
